// File: rtl/dmem_resp_pkg.sv
// Shared types for the data-memory response block: access-size codes, FSM states,
// the captured-request record and the lane-mask / load-extension helpers.
package dmem_resp_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT2 = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Everything the second beat and the load response need once the inputs have moved on.
   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [1:0]  off;
      logic [3:0]  be_hi;
      logic [31:0] wdata_hi;
   } req_t;

   // 8-lane mask across the addressed word and the next one; bits [7:4] set means a spill.
   function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [7:0] m;
      case (size)
         SZ_BYTE: m = 8'h01;
         SZ_HALF: m = 8'h03;
         default: m = 8'h0F;
      endcase
      return m << off;
   endfunction

   function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] size,
                                               input logic uns);
      logic [31:0] r;
      case (size)
         SZ_BYTE: r = {{24{~uns & d[7]}}, d[7:0]};
         SZ_HALF: r = {{16{~uns & d[15]}}, d[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables.
// Latency: read data registered, valid the cycle after the access edge.
// Backpressure: none; accepts an access every cycle.
module dmem_sram #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    be,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Read port only updates on loads so the previous load word survives an intervening store.
   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      if (en && !we) rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory access unit: byte/half/word loads and stores, word-crossing split into two beats.
// Latency: aligned load 1 cycle, crossing load 2 cycles; stores produce no response.
// Backpressure: req_ready_o low during the second beat of a crossing access and in reset.
module dmem_resp
   import dmem_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t        state;
   req_t          req_q;
   logic [AW-1:0] widx_hi_q;
   logic          crossed_q;
   logic          rdy_q;
   logic [31:0]   lo_q;
   logic [31:0]   rdata_q;

   logic          accept;
   logic [1:0]    off;
   logic [AW-1:0] widx;
   logic [7:0]    be8;
   logic [63:0]   wd64;
   logic          spill;
   logic          addr_unused;

   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [3:0]    ram_be;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;

   logic [63:0]   merged;
   logic [31:0]   ld_sel;
   logic [31:0]   ld_data;

   assign off         = addr_i[1:0];
   assign widx        = addr_i[AW+1:2];
   assign addr_unused = ^addr_i[31:AW+2];
   assign be8         = lane_mask(size_i, off);
   assign wd64        = {32'h0, wdata_i} << {off, 3'b000};
   assign spill       = |be8[7:4];

   // rdy_q keeps ready low through reset without routing rst_n into the datapath.
   assign req_ready_o = rdy_q && (state != BEAT2);
   assign accept      = req_valid_i && req_ready_o;
   assign misalign_o  = accept && spill;
   assign rvalid_o    = (state == RESP);

   always_comb begin
      if (state == BEAT2) begin
         ram_en    = 1'b1;
         ram_we    = req_q.we;
         ram_addr  = widx_hi_q;
         ram_be    = req_q.be_hi;
         ram_wdata = req_q.wdata_hi;
      end else begin
         ram_en    = accept;
         ram_we    = we_i;
         ram_addr  = widx;
         ram_be    = be8[3:0];
         ram_wdata = wd64[31:0];
      end
   end

   dmem_sram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_sram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .be    (ram_be),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Little-endian merge: the addressed word supplies the low bytes, the spill word the high ones.
   assign merged  = crossed_q ? {ram_rdata, lo_q} : {32'h0, ram_rdata};
   assign ld_sel  = 32'(merged >> {req_q.off, 3'b000});
   assign ld_data = load_extend(ld_sel, req_q.size, req_q.uns);
   assign rdata_o = rvalid_o ? ld_data : rdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_q     <= '0;
         widx_hi_q <= '0;
         crossed_q <= 1'b0;
         rdy_q     <= 1'b0;
         lo_q      <= '0;
         rdata_q   <= '0;
      end else begin
         rdy_q <= 1'b1;
         if (state == RESP)  rdata_q <= ld_data;
         if (state == BEAT2) lo_q    <= ram_rdata;
         if (accept) begin
            req_q     <= '{we: we_i, size: size_i, uns: unsigned_i, off: off,
                           be_hi: be8[7:4], wdata_hi: wd64[63:32]};
            widx_hi_q <= widx + AW'(1);
            crossed_q <= spill;
         end
         case (state)
            IDLE, RESP: begin
               if (accept) begin
                  if (spill)     state <= BEAT2;
                  else if (we_i) state <= IDLE;
                  else           state <= RESP;
               end else begin
                  state <= IDLE;
               end
            end
            BEAT2:   state <= req_q.we ? IDLE : RESP;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: vector table of single accesses plus reset,
// back-to-back and reset-during-second-beat sequences.
module tb_dmem_resp;

   localparam logic [1:0] B = 2'b00;
   localparam logic [1:0] H = 2'b01;
   localparam logic [1:0] W = 2'b10;
   localparam int NV = 30;

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp;
      logic        mis;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [31:0] addr_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic        unsigned_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        misalign_o;

   int n_cmp = 0;
   int n_bad = 0;
   vec_t vt [NV];

   dmem_resp #(.DEPTH_WORDS(1024)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .addr_i      (addr_i),
      .we_i        (we_i),
      .size_i      (size_i),
      .unsigned_i  (unsigned_i),
      .wdata_i     (wdata_i),
      .rvalid_o    (rvalid_o),
      .rdata_o     (rdata_o),
      .misalign_o  (misalign_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic scramble();
      addr_i     = $urandom;
      wdata_i    = $urandom;
      size_i     = 2'($urandom_range(0, 3));
      unsigned_i = 1'($urandom_range(0, 1));
      we_i       = 1'($urandom_range(0, 1));
   endtask

   task automatic do_req(input string name, input vec_t v);
      int n;
      @(negedge clk);
      req_valid_i = 1'b1;
      we_i        = v.we;
      size_i      = v.sz;
      unsigned_i  = v.uns;
      addr_i      = v.addr;
      wdata_i     = v.wd;
      #1;
      n = 0;
      while (!req_ready_o && n < 8) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk({name, ".rdy"}, 32'(req_ready_o), 32'd1);
      chk({name, ".mis"}, 32'(misalign_o), 32'(v.mis));
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      scramble();
      @(negedge clk);
      chk({name, ".rdy1"}, 32'(req_ready_o), 32'(!v.mis));
      if (v.we) begin
         chk({name, ".nov1"}, 32'(rvalid_o), 32'd0);
         if (v.mis) begin
            @(negedge clk);
            chk({name, ".nov2"}, 32'(rvalid_o), 32'd0);
         end
      end else begin
         if (v.mis) begin
            chk({name, ".early"}, 32'(rvalid_o), 32'd0);
            @(negedge clk);
         end
         chk({name, ".rvld"}, 32'(rvalid_o), 32'd1);
         chk({name, ".rdat"}, rdata_o, v.exp);
         @(negedge clk);
         chk({name, ".pulse"}, 32'(rvalid_o), 32'd0);
         chk({name, ".hold"}, rdata_o, v.exp);
      end
   endtask

   initial begin
      vt[0]  = '{1'b1, W, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0, 1'b0};
      vt[1]  = '{1'b0, W, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b0, B, 1'b0, 32'h013, 32'h0, 32'hFFFFFFDE, 1'b0};
      vt[3]  = '{1'b0, B, 1'b1, 32'h013, 32'h0, 32'h000000DE, 1'b0};
      vt[4]  = '{1'b0, H, 1'b0, 32'h012, 32'h0, 32'hFFFFDEAD, 1'b0};
      vt[5]  = '{1'b0, H, 1'b1, 32'h012, 32'h0, 32'h0000DEAD, 1'b0};
      vt[6]  = '{1'b0, B, 1'b0, 32'h010, 32'h0, 32'hFFFFFFEF, 1'b0};
      vt[7]  = '{1'b0, B, 1'b1, 32'h011, 32'h0, 32'h000000BE, 1'b0};
      vt[8]  = '{1'b0, 2'b11, 1'b0, 32'h010, 32'h0, 32'hDEADBEEF, 1'b0};
      vt[9]  = '{1'b0, W, 1'b0, 32'hFFFFF010, 32'h0, 32'hDEADBEEF, 1'b0};
      vt[10] = '{1'b1, W, 1'b0, 32'h00C, 32'h11223344, 32'h0, 1'b0};
      vt[11] = '{1'b0, W, 1'b0, 32'h00E, 32'h0, 32'hBEEF1122, 1'b1};
      vt[12] = '{1'b1, W, 1'b0, 32'h01C, 32'h0, 32'h0, 1'b0};
      vt[13] = '{1'b1, W, 1'b0, 32'h020, 32'h0, 32'h0, 1'b0};
      vt[14] = '{1'b1, H, 1'b0, 32'h01F, 32'h0000A55A, 32'h0, 1'b1};
      vt[15] = '{1'b0, W, 1'b0, 32'h01C, 32'h0, 32'h5A000000, 1'b0};
      vt[16] = '{1'b0, W, 1'b0, 32'h020, 32'h0, 32'h000000A5, 1'b0};
      vt[17] = '{1'b0, H, 1'b0, 32'h01F, 32'h0, 32'hFFFFA55A, 1'b1};
      vt[18] = '{1'b0, H, 1'b1, 32'h01F, 32'h0, 32'h0000A55A, 1'b1};
      vt[19] = '{1'b1, W, 1'b0, 32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0};
      vt[20] = '{1'b1, W, 1'b0, 32'h000, 32'h01020304, 32'h0, 1'b0};
      vt[21] = '{1'b0, W, 1'b0, 32'hFFE, 32'h0, 32'h0304CAFE, 1'b1};
      vt[22] = '{1'b1, B, 1'b0, 32'h011, 32'hAAAAAA77, 32'h0, 1'b0};
      vt[23] = '{1'b0, W, 1'b0, 32'h010, 32'h0, 32'hDEAD77EF, 1'b0};
      vt[24] = '{1'b1, W, 1'b0, 32'h01E, 32'h55667788, 32'h0, 1'b1};
      vt[25] = '{1'b0, W, 1'b0, 32'h01C, 32'h0, 32'h77880000, 1'b0};
      vt[26] = '{1'b0, W, 1'b0, 32'h020, 32'h0, 32'h00005566, 1'b0};
      vt[27] = '{1'b1, H, 1'b0, 32'hFFF, 32'h0000BEEF, 32'h0, 1'b1};
      vt[28] = '{1'b0, W, 1'b0, 32'hFFC, 32'h0, 32'hEFFEF00D, 1'b0};
      vt[29] = '{1'b0, W, 1'b0, 32'h000, 32'h0, 32'h010203BE, 1'b0};

      // Reset state, with a crossing request presented throughout.
      rst_n       = 1'b0;
      req_valid_i = 1'b1;
      we_i        = 1'b0;
      size_i      = W;
      unsigned_i  = 1'b0;
      addr_i      = 32'h0E;
      wdata_i     = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst.rdy", 32'(req_ready_o), 32'd0);
      chk("rst.rvld", 32'(rvalid_o), 32'd0);
      chk("rst.rdat", rdata_o, 32'h0);
      chk("rst.mis", 32'(misalign_o), 32'd0);
      req_valid_i = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel.rdy", 32'(req_ready_o), 32'd1);
      chk("rel.rvld", 32'(rvalid_o), 32'd0);

      for (int i = 0; i < NV; i++) do_req($sformatf("v%0d", i), vt[i]);

      // Alternating store/load to one address with valid held high: no stalls.
      @(negedge clk);
      req_valid_i = 1'b1;
      unsigned_i  = 1'b0;
      size_i      = W;
      addr_i      = 32'h40;
      we_i        = 1'b1;
      wdata_i     = 32'h1000_0000;
      #1;
      chk("b2b.rdy0", 32'(req_ready_o), 32'd1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("b2b%0d.st_nov", k), 32'(rvalid_o), 32'd0);
         chk($sformatf("b2b%0d.rdy_ld", k), 32'(req_ready_o), 32'd1);
         we_i    = 1'b0;
         wdata_i = 32'h0;
         @(negedge clk);
         chk($sformatf("b2b%0d.rvld", k), 32'(rvalid_o), 32'd1);
         chk($sformatf("b2b%0d.rdat", k), rdata_o, 32'h1000_0000 + 32'(k) * 32'h0101_0101);
         chk($sformatf("b2b%0d.rdy_st", k), 32'(req_ready_o), 32'd1);
         if (k < 3) begin
            we_i    = 1'b1;
            wdata_i = 32'h1000_0000 + 32'(k + 1) * 32'h0101_0101;
         end else begin
            req_valid_i = 1'b0;
         end
      end

      // Reset during the second beat of a crossing store.
      do_req("pre30", '{1'b1, W, 1'b0, 32'h030, 32'h00000000, 32'h0, 1'b0});
      do_req("pre34", '{1'b1, W, 1'b0, 32'h034, 32'h11111111, 32'h0, 1'b0});
      @(negedge clk);
      req_valid_i = 1'b1;
      we_i        = 1'b1;
      size_i      = W;
      addr_i      = 32'h032;
      wdata_i     = 32'hAABBCCDD;
      #1;
      chk("rb2.mis", 32'(misalign_o), 32'd1);
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      @(negedge clk);
      chk("rb2.beat2", 32'(req_ready_o), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rb2.rdy", 32'(req_ready_o), 32'd0);
      chk("rb2.rvld", 32'(rvalid_o), 32'd0);
      chk("rb2.rdat", rdata_o, 32'h0);
      chk("rb2.mis0", 32'(misalign_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rb2.rel_rdy", 32'(req_ready_o), 32'd1);
      chk("rb2.rel_rvld", 32'(rvalid_o), 32'd0);
      chk("rb2.rel_rdat", rdata_o, 32'h0);
      do_req("rb2.hi", '{1'b0, W, 1'b0, 32'h034, 32'h0, 32'h11111111, 1'b0});
      do_req("rb2.lo", '{1'b0, W, 1'b0, 32'h030, 32'h0, 32'hCCDD0000, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the internal data RAM; power of two.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 req_valid_i  input  1  pipeline presents a data-memory access this cycle.
REQ-005 req_ready_o  output  1  block accepts the request this cycle; transfer occurs when req_valid_i and req_ready_o are both high.
REQ-006 addr_i  input  32  byte address; only bits [log2(DEPTH_WORDS)+1:0] used, upper bits ignored.
REQ-007 we_i  input  1  1 = store, 0 = load.
REQ-008 size_i  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-009 unsigned_i  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 wdata_i  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-011 rvalid_o  output  1  one-cycle pulse, load data valid.
REQ-012 rdata_o  output  32  extended, right-justified load data; holds its value until the next rvalid_o.
REQ-013 misalign_o  output  1  one-cycle pulse, coincident with the accepting cycle, when the access crosses a word boundary.

Function
REQ-014 States: IDLE, BEAT2, RESP; req_ready_o high only in IDLE and RESP.
REQ-015 Lane enables: byte -> 1 lane at addr[1:0]; half -> 2 lanes from addr[1:0]; word -> 4 lanes from addr[1:0]; lanes beyond 3 spill into word addr+4.
REQ-016 Aligned store (no spill): RAM write at the accepting edge, byte-enabled; no rvalid_o; state stays IDLE.
REQ-017 Aligned load: RAM read at the accepting edge; rvalid_o high the following cycle (latency 1); state -> RESP for that cycle.
REQ-018 Crossing access: first word written/read at the accepting edge; state -> BEAT2; second word (addr+4, wrapping modulo DEPTH_WORDS) accessed at the next edge; req_ready_o low in BEAT2.
REQ-019 Crossing load: rvalid_o one cycle after BEAT2 (latency 2), data merged from both words.
REQ-020 Crossing store: both partial writes complete by the end of BEAT2; no rvalid_o.
REQ-021 Extension: byte uses bit 7, half bit 15 of the extracted value as sign unless unsigned_i; word is unchanged.
REQ-022 Load/store parameters are captured at acceptance; input changes afterwards have no effect.
REQ-023 Back-to-back: a new request is accepted in RESP; a load issued the cycle after a store to the same bytes returns the stored data.
REQ-024 Last word of the RAM plus spill wraps to word 0.

Reset
REQ-025 On rst_n low: state IDLE, req_ready_o 0 while asserted and 1 the first cycle after release, rvalid_o 0, rdata_o 0, misalign_o 0.
REQ-026 RAM contents are not reset.
REQ-027 Reset during BEAT2 aborts the second beat: no second write, no rvalid_o.

Structure
REQ-028 Shared package holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state enum.
REQ-029 One sub-module, dmem_sram: synchronous read, 4-lane byte-enable write, DEPTH_WORDS x 32.

Verification
REQ-030 Store word 0xDEADBEEF @0x10, load word @0x10 -> rvalid_o after 1 cycle, rdata_o 0xDEADBEEF.
REQ-031 Load byte @0x13, signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; half @0x12 signed -> 0xFFFFDEAD.
REQ-032 Store half 0xA55A @0x1F, load word @0x1C and @0x20 -> [31:24] of first = 0x5A, [7:0] of second = 0xA5; misalign_o pulses on the store; req_ready_o low 1 cycle.
REQ-033 Load word @0x0E with 0x10 = 0xDEADBEEF, 0x0C = 0x11223344 -> rvalid_o at latency 2, rdata_o 0xBEEF1122.
REQ-034 Crossing store accepted, rst_n pulsed low in BEAT2 -> second word unchanged, rvalid_o never high, outputs 0.
REQ-035 Continuous req_valid_i with alternating aligned store/load to the same address -> every load returns the immediately preceding store value, no stall cycles.
